// File: rtl/audio_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : audio_frame_scheduler
// Description : Sends stereo audio to the driver FIFO at a fixed rate. A clock
//               divider makes one frame tick every SAMPLE_DIV cycles. On each
//               tick the scheduler writes one left word and then one right
//               word into the FIFO stream. It waits one bubble cycle between
//               the two writes. It obeys the FIFO's per-channel source_ready.
//               It counts frames that the producers did not complete before
//               the next tick.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : DATA_SIZE  - sample / FIFO word width
//               SAMPLE_DIV - clk cycles per frame tick (>= 4)
// Ports       : clk, rst        - clock, synchronous active-high reset
//               enable          - runs the divider and scheduler
//               l_valid/l_data/l_ready - left-channel producer handshake
//               r_valid/r_data/r_ready - right-channel producer handshake
//               sink_valid/sink_data   - FIFO write strobe and word
//               sink_ready[1:0] - FIFO space; bit0 gates L, bit1 gates R
//               underrun_cnt    - saturating count of missed frames
//               busy            - frame in progress (waiting for L or R)
// Config      : AUDIO_SCHED_TAG_EN - when defined, the channel id (0=L, 1=R)
//               replaces the MSB of sink_data
// ============================================================================
module audio_frame_scheduler #(
  parameter int DATA_SIZE  = 28,
  parameter int SAMPLE_DIV = 1042
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 l_valid,
  input  logic [DATA_SIZE-1:0] l_data,
  output logic                 l_ready,
  input  logic                 r_valid,
  input  logic [DATA_SIZE-1:0] r_data,
  output logic                 r_ready,
  output logic                 sink_valid,
  output logic [DATA_SIZE-1:0] sink_data,
  input  logic [1:0]           sink_ready,
  output logic [15:0]          underrun_cnt,
  output logic                 busy
);

  localparam int             DIV_W    = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT_L = 2'd1;
  localparam logic [1:0] ST_WAIT_R = 2'd2;

  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [1:0]           state_q, state_d;
  logic                 sink_valid_q, sink_valid_d;
  logic [DATA_SIZE-1:0] sink_data_q, sink_data_d;
  logic [15:0]          underrun_q, underrun_d;

  logic                 w_tick;
  logic                 w_l_xfer;
  logic                 w_r_xfer;
  logic                 w_underrun;
  logic [DATA_SIZE-1:0] w_l_word;
  logic [DATA_SIZE-1:0] w_r_word;

  // ---------------------------------------------------------------- divider
  assign w_tick = enable & (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    if (!enable || w_tick) begin
      div_cnt_d = '0;
    end
  end

  // ---------------------------------------------------------- ready / xfer
  // The ~sink_valid term inserts a bubble after every write. sink_ready
  // shows the FIFO write only one cycle late, so without the bubble L and R
  // could both target one free slot. Gating with enable stops new
  // handshakes in the cycle where enable drops.
  assign l_ready  = enable & (state_q == ST_WAIT_L) & sink_ready[0] & ~sink_valid_q;
  assign r_ready  = enable & (state_q == ST_WAIT_R) & sink_ready[1] & ~sink_valid_q;
  assign w_l_xfer = l_valid & l_ready;
  assign w_r_xfer = r_valid & r_ready;

`ifdef AUDIO_SCHED_TAG_EN
  assign w_l_word = {1'b0, l_data[DATA_SIZE-2:0]};
  assign w_r_word = {1'b1, r_data[DATA_SIZE-2:0]};
`else
  assign w_l_word = l_data;
  assign w_r_word = r_data;
`endif

  // -------------------------------------------------------------------- FSM
  always_comb begin
    state_d    = state_q;
    w_underrun = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_tick) state_d = ST_WAIT_L;
        end
        ST_WAIT_L: begin
          // A tick before the L word arrives drops the frame. Any L word
          // accepted in that same cycle is still written.
          if (w_tick) begin
            w_underrun = 1'b1;
            state_d    = ST_WAIT_L;
          end else if (w_l_xfer) begin
            state_d = ST_WAIT_R;
          end
        end
        ST_WAIT_R: begin
          if (w_r_xfer) begin
            state_d = w_tick ? ST_WAIT_L : ST_IDLE;
          end else if (w_tick) begin
            w_underrun = 1'b1;
            state_d    = ST_WAIT_L;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------ output registers
  always_comb begin
    sink_valid_d = w_l_xfer | w_r_xfer;
    sink_data_d  = sink_data_q;
    if (w_l_xfer) sink_data_d = w_l_word;
    if (w_r_xfer) sink_data_d = w_r_word;
    underrun_d = underrun_q;
    if (w_underrun && (underrun_q != 16'hFFFF)) begin
      underrun_d = underrun_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      state_q      <= ST_IDLE;
      sink_valid_q <= 1'b0;
      sink_data_q  <= '0;
      underrun_q   <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      state_q      <= state_d;
      sink_valid_q <= sink_valid_d;
      sink_data_q  <= sink_data_d;
      underrun_q   <= underrun_d;
    end
  end

  assign sink_valid   = sink_valid_q;
  assign sink_data    = sink_data_q;
  assign underrun_cnt = underrun_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_audio_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_frame_scheduler
// Description : Self-checking bench for audio_frame_scheduler. It compares the
//               DUT every cycle against a frame-level reference model, and it
//               also checks directed scenarios against literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_frame_scheduler;

  localparam int DW  = 28;
  localparam int DIV = 8;

  logic          clk = 1'b0;
  logic          rst, enable, l_valid, r_valid;
  logic [DW-1:0] l_data, r_data;
  logic [1:0]    sink_ready;
  logic          l_ready, r_ready, sink_valid, busy;
  logic [DW-1:0] sink_data;
  logic [15:0]   underrun_cnt;

  audio_frame_scheduler #(.DATA_SIZE(DW), .SAMPLE_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .l_valid(l_valid), .l_data(l_data), .l_ready(l_ready),
    .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready),
    .sink_valid(sink_valid), .sink_data(sink_data), .sink_ready(sink_ready),
    .underrun_cnt(underrun_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int cyc_n    = 0;

  // Log of words the DUT actually wrote, and the cycle in which each appeared.
  logic [DW-1:0] wq[$];
  int            cq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------- reference model
  // Frame view: a frame opens on a tick and needs an L word followed by an
  // R word. A cycle after any write is a bubble. A tick that arrives while
  // the frame is still open counts as a miss and starts a new frame.
  int            m_div    = 0;
  bit            m_open   = 0;
  bit            m_have_l = 0;
  bit            m_sv     = 0;
  logic [DW-1:0] m_sd     = '0;
  int            m_uc     = 0;

  function automatic logic [DW-1:0] word(input logic [DW-1:0] d, input bit ch);
`ifdef AUDIO_SCHED_TAG_EN
    logic [DW-1:0] t;
    t = d;
    t[DW-1] = ch;
    return t;
`else
    return d;
`endif
  endfunction

  always @(negedge clk) begin
    bit e_lr, e_rr, tick, lx, rx;
    cyc_n++;
    e_lr = enable && m_open && !m_have_l && sink_ready[0] && !m_sv;
    e_rr = enable && m_open &&  m_have_l && sink_ready[1] && !m_sv;
    if (chk_en) begin
      chk("sink_valid", {31'd0, sink_valid}, {31'd0, m_sv});
      chk("sink_data", {4'd0, sink_data}, {4'd0, m_sd});
      chk("underrun_cnt", {16'd0, underrun_cnt}, m_uc);
      chk("busy", {31'd0, busy}, {31'd0, m_open});
      chk("l_ready", {31'd0, l_ready}, {31'd0, e_lr});
      chk("r_ready", {31'd0, r_ready}, {31'd0, e_rr});
    end
    if (sink_valid === 1'b1) begin
      wq.push_back(sink_data);
      cq.push_back(cyc_n);
    end
    if (rst) begin
      m_div = 0; m_open = 0; m_have_l = 0; m_sv = 0; m_sd = '0; m_uc = 0;
    end else begin
      tick  = enable && (m_div == DIV - 1);
      m_div = (!enable || tick) ? 0 : m_div + 1;
      lx    = l_valid && e_lr;
      rx    = r_valid && e_rr;
      m_sv  = lx || rx;
      if (lx) m_sd = word(l_data, 1'b0);
      if (rx) m_sd = word(r_data, 1'b1);
      if (!enable) begin
        m_open = 0; m_have_l = 0;
      end else if (tick) begin
        // A frame that is still open and not completed this cycle is missed.
        if (m_open && !rx && m_uc < 16'hFFFF) m_uc++;
        m_open = 1; m_have_l = 0;
      end else if (lx) begin
        m_have_l = 1;
      end else if (rx) begin
        m_open = 0; m_have_l = 0;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    int  t;
    bit  seen;
    rst = 1'b1; enable = 1'b0; l_valid = 1'b0; r_valid = 1'b0;
    l_data = '0; r_data = '0; sink_ready = 2'b11;
    cyc(2);
    chk_en = 1'b1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_sink_valid", {31'd0, sink_valid}, 32'd0);
    chk("reset_underrun", {16'd0, underrun_cnt}, 32'd0);

    // Normal frames: L at T+2, R at T+4
    rst = 1'b0; enable = 1'b1; l_valid = 1'b1; r_valid = 1'b1;
    l_data = 28'h0000AAA; r_data = 28'h0000BBB;
    wq.delete(); cq.delete();
    cyc(30);
    chk("t1_two_writes", {31'd0, wq.size() >= 2}, 32'd1);
    chk("t1_L_word", {4'd0, wq[0]}, 32'h0000AAA);
    chk("t1_R_word", {4'd0, wq[1]}, 32'h0000BBB);
    chk("t1_bubble_gap", cq[1] - cq[0], 32'd2);
    chk("t1_underrun", {16'd0, underrun_cnt}, 32'd0);

    // Late right: drop r_valid just after an L write, across one tick
    wq.delete();
    t = 0;
    while (wq.size() == 0 && t < 20) begin cyc(1); t++; end
    if (wq.size() == 0) chk("t2_timeout", 32'd1, 32'd0);
    r_valid = 1'b0;
    wq.delete();
    cyc(8);
    chk("t2_underrun", {16'd0, underrun_cnt}, 32'd1);
    seen = 1'b0;
    foreach (wq[i]) if (wq[i] == 28'h0000BBB) seen = 1'b1;
    chk("t2_no_R_written", {31'd0, seen}, 32'd0);
    r_valid = 1'b1;
    cyc(20);

    // FIFO full: start right after a completed frame
    wq.delete();
    t = 0;
    while (!(wq.size() > 0 && wq[wq.size()-1] == 28'h0000BBB) && t < 20) begin cyc(1); t++; end
    if (t >= 20) chk("t3_timeout", 32'd1, 32'd0);
    sink_ready = 2'b00;
    wq.delete();
    cyc(20);
    chk("t3_no_writes_full", wq.size(), 32'd0);
    sink_ready = 2'b11;
    cyc(30);
    chk("t3_resume_L", {4'd0, wq[0]}, 32'h0000AAA);
    chk("t3_resume_R", {4'd0, wq[1]}, 32'h0000BBB);

    // Saturation: preload the counter near the top to keep the run short
    l_valid = 1'b0;
    force dut.underrun_q = 16'hFFFC;
    m_uc = 16'hFFFC;
    @(negedge clk);
    #1;
    release dut.underrun_q;
    cyc(DIV * 10);
    chk("t4_saturated", {16'd0, underrun_cnt}, 32'h0000FFFF);

    // Disable while waiting for R
    do_reset();
    l_valid = 1'b1; r_valid = 1'b0; enable = 1'b1;
    t = 0;
    while (!(m_open && m_have_l) && t < 40) begin cyc(1); t++; end
    if (t >= 40) chk("t5_timeout_R", 32'd1, 32'd0);
    r_valid = 1'b1;
    enable  = 1'b0;
    cyc(1);
    chk("t5_disable_busy", {31'd0, busy}, 32'd0);
    chk("t5_disable_r_ready", {31'd0, r_ready}, 32'd0);
    cyc(3);

    // Reset while waiting for L
    enable = 1'b1; l_valid = 1'b0;
    t = 0;
    while (!(m_open && !m_have_l) && t < 40) begin cyc(1); t++; end
    if (t >= 40) chk("t5_timeout_L", 32'd1, 32'd0);
    rst = 1'b1;
    cyc(1);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_l_ready", {31'd0, l_ready}, 32'd0);
    chk("t5_rst_sink_valid", {31'd0, sink_valid}, 32'd0);
    chk("t5_rst_sink_data", {4'd0, sink_data}, 32'd0);
    chk("t5_rst_underrun", {16'd0, underrun_cnt}, 32'd0);
    rst = 1'b0;

`ifdef AUDIO_SCHED_TAG_EN
    l_valid = 1'b1; r_valid = 1'b1; l_data = 28'hFFFFFFF; r_data = 28'hFFFFFFF;
    wq.delete();
    cyc(20);
    chk("t6_tag_L", {4'd0, wq[0]}, 32'h07FFFFFF);
    chk("t6_tag_R", {4'd0, wq[1]}, 32'h0FFFFFFF);
`endif

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      l_valid    = ($urandom_range(0, 99) < 75);
      r_valid    = ($urandom_range(0, 99) < 75);
      l_data     = DW'($urandom);
      r_data     = DW'($urandom);
      sink_ready = ($urandom_range(0, 99) < 70) ? 2'b11 : 2'($urandom);
      enable     = ($urandom_range(0, 99) < 98);
      rst        = ($urandom_range(0, 999) < 3);
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
